// File: rtl/ff_pipe.sv
// ff_pipe: DEPTH-stage enabled data pipeline with per-stage valid bits.
// Bubbles advance the valid chain but never overwrite stage data, so out
// keeps the last valid sample that reached the final stage.
module ff_pipe #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       clr,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in,
    output logic [WIDTH-1:0]           out,
    output logic                       out_valid,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);

    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] v;
    logic [OCC_W-1:0] occ_nxt;

    // Occupancy tracks entering minus leaving samples, bounded to 0..DEPTH.
    always_comb begin
        occ_nxt = occupancy;
        if (in_valid && !v[DEPTH-1] && (occupancy != OCC_MAX)) begin
            occ_nxt = occupancy + OCC_W'(1);
        end else if (!in_valid && v[DEPTH-1] && (occupancy != '0)) begin
            occ_nxt = occupancy - OCC_W'(1);
        end
    end

    // Stage registers: reset > clr > en > hold; data moves only behind a valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                d[k] <= RESET_VAL;
            end
            v         <= '0;
            occupancy <= '0;
        end else if (clr) begin
            for (int k = 0; k < DEPTH; k++) begin
                d[k] <= RESET_VAL;
            end
            v         <= '0;
            occupancy <= '0;
        end else if (en) begin
            v[0] <= in_valid;
            if (in_valid) begin
                d[0] <= in;
            end
            for (int k = 1; k < DEPTH; k++) begin
                v[k] <= v[k-1];
                if (v[k-1]) begin
                    d[k] <= d[k-1];
                end
            end
            occupancy <= occ_nxt;
        end
    end

    // Outputs come straight from the final stage registers.
    assign out       = d[DEPTH-1];
    assign out_valid = v[DEPTH-1];

endmodule
